// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, the ID/EX entry layout and small decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        reg_write;
    logic        is_load;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
  } idex_t;

  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction

  function automatic logic [4:0] dest_reg(input logic [5:0] op,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
    if (op == OP_RTYPE)                                     return rd;
    else if ((op >= OP_ADDI && op <= OP_LUI) || op == OP_LW) return rt;
    else if (op == OP_JAL)                                  return REG_RA;
    else                                                    return REG_ZERO;
  endfunction

  // $0 is never a producer, so a zero dest can never match a source field.
  function automatic logic reg_match(input logic [4:0] dest,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       use_rt);
    return (dest != REG_ZERO) && ((dest == rs) || (use_rt && (dest == rt)));
  endfunction

endpackage

// File: rtl/mips_operand_sel.sv
// One operand port: forces $0 to zero, optionally forwards the writeback bus,
// otherwise passes the register file read data.
module mips_operand_sel
  import mips_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic [4:0]  addr,
  input  logic [31:0] rd_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] val
);

  always_comb begin
    val = rd_data;
    if (addr == REG_ZERO)
      val = '0;
    else if (BYPASS && wb_en && (wb_addr == addr))
      val = wb_data;
  end

endmodule

// File: rtl/mips_operand_fetch.sv
// ID-stage operand fetch with load-use interlock and a one-entry ID/EX register.
// Define OPFETCH_WB_BYPASS_EN to forward the writeback bus into the operands.
module mips_operand_fetch
  import mips_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] InInstr,
  input  logic [31:0] InPC,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        WbRegWrite,
  input  logic [4:0]  WbWriteRegister,
  input  logic [31:0] WbWriteData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutRsVal,
  output logic [31:0] OutRtVal,
  output logic [31:0] OutImm,
  output logic [4:0]  OutDest,
  output logic        OutRegWrite,
  output logic        OutIsLoad,
  output logic [5:0]  OutOpcode,
  output logic [5:0]  OutFunct,
  output logic [31:0] OutPC
);

`ifdef OPFETCH_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  // Without forwarding the tracker stays armed one cycle past the writeback,
  // so the consumer reads the value already committed to the register file.
  localparam int unsigned TRK_INIT = BYPASS ? LOAD_LAT : LOAD_LAT + 1;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic        use_rt;
  logic [31:0] rs_val, rt_val;
  idex_t       entry, next_entry;
  logic [2:0]  trk_cnt;
  logic [4:0]  trk_dest;
  logic        ex_hit, trk_hit, wb_hit, stall;
  logic        capture, drain;

  assign opcode        = InInstr[31:26];
  assign rs            = InInstr[25:21];
  assign rt            = InInstr[20:16];
  assign rd            = InInstr[15:11];
  assign use_rt        = uses_rt(opcode);
  assign ReadRegister1 = rs;
  assign ReadRegister2 = rt;

  mips_operand_sel #(.BYPASS(BYPASS)) u_sel_rs (
    .addr    (rs),
    .rd_data (ReadData1),
    .wb_en   (WbRegWrite),
    .wb_addr (WbWriteRegister),
    .wb_data (WbWriteData),
    .val     (rs_val)
  );

  mips_operand_sel #(.BYPASS(BYPASS)) u_sel_rt (
    .addr    (rt),
    .rd_data (ReadData2),
    .wb_en   (WbRegWrite),
    .wb_addr (WbWriteRegister),
    .wb_data (WbWriteData),
    .val     (rt_val)
  );

  always_comb begin
    ex_hit  = OutValid && OutIsLoad && reg_match(OutDest, rs, rt, use_rt);
    trk_hit = (trk_cnt != '0) && reg_match(trk_dest, rs, rt, use_rt);
    wb_hit  = !BYPASS && WbRegWrite && reg_match(WbWriteRegister, rs, rt, use_rt);
    stall   = ex_hit || trk_hit || wb_hit;
  end

  assign InReady = !stall && (!OutValid || OutReady);
  assign capture = InValid && InReady;
  assign drain   = OutValid && OutReady;

  always_comb begin
    next_entry           = '0;
    next_entry.rs_val    = rs_val;
    next_entry.rt_val    = rt_val;
    next_entry.imm       = {{16{InInstr[15]}}, InInstr[15:0]};
    next_entry.dest      = dest_reg(opcode, rt, rd);
    next_entry.reg_write = (dest_reg(opcode, rt, rd) != REG_ZERO);
    next_entry.is_load   = (opcode == OP_LW);
    next_entry.opcode    = opcode;
    next_entry.funct     = InInstr[5:0];
    next_entry.pc        = InPC;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutValid <= 1'b0;
      entry    <= '0;
    end else if (capture) begin
      OutValid <= 1'b1;
      entry    <= next_entry;
    end else if (drain) begin
      OutValid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      trk_cnt  <= '0;
      trk_dest <= '0;
    end else if (drain && OutIsLoad && (OutDest != REG_ZERO)) begin
      trk_cnt  <= 3'(TRK_INIT);
      trk_dest <= OutDest;
    end else if (trk_cnt != '0) begin
      trk_cnt  <= trk_cnt - 3'd1;
    end
  end

  assign OutRsVal    = entry.rs_val;
  assign OutRtVal    = entry.rt_val;
  assign OutImm      = entry.imm;
  assign OutDest     = entry.dest;
  assign OutRegWrite = entry.reg_write;
  assign OutIsLoad   = entry.is_load;
  assign OutOpcode   = entry.opcode;
  assign OutFunct    = entry.funct;
  assign OutPC       = entry.pc;

endmodule

// File: tb/tb_mips_operand_fetch.sv
// Directed + randomized bench for mips_operand_fetch against a cycle-indexed
// reference model (absolute due-cycle for the pending load, not a countdown).
module tb_mips_operand_fetch;

  localparam int unsigned LAT = 2;
`ifdef OPFETCH_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk, Rst_n;
  logic        InValid, InReady;
  logic [31:0] InInstr, InPC;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;
  logic        WbRegWrite;
  logic [4:0]  WbWriteRegister;
  logic [31:0] WbWriteData;
  logic        OutValid, OutReady;
  logic [31:0] OutRsVal, OutRtVal, OutImm, OutPC;
  logic [4:0]  OutDest;
  logic        OutRegWrite, OutIsLoad;
  logic [5:0]  OutOpcode, OutFunct;

  mips_operand_fetch #(.LOAD_LAT(LAT)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .InValid(InValid), .InReady(InReady), .InInstr(InInstr), .InPC(InPC),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WbRegWrite(WbRegWrite), .WbWriteRegister(WbWriteRegister), .WbWriteData(WbWriteData),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutRsVal(OutRsVal), .OutRtVal(OutRtVal), .OutImm(OutImm), .OutDest(OutDest),
    .OutRegWrite(OutRegWrite), .OutIsLoad(OutIsLoad), .OutOpcode(OutOpcode),
    .OutFunct(OutFunct), .OutPC(OutPC)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  // Reference model state
  bit          m_valid, m_rw, m_ld, m_cap, p_on;
  logic [31:0] m_rs, m_rt, m_imm, m_pc;
  logic [4:0]  m_dest, p_dest;
  logic [5:0]  m_op, m_fn;
  int          p_due;
  bit          last_dut_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] f_dest(input logic [31:0] i);
    int op;
    op = int'(i[31:26]);
    if (op == 0) return i[15:11];
    if ((op >= 8 && op <= 15) || op == 35) return i[20:16];
    if (op == 3) return 5'd31;
    return 5'd0;
  endfunction

  function automatic bit f_uses_rt(input logic [31:0] i);
    return int'(i[31:26]) inside {0, 4, 5, 43};
  endfunction

  function automatic bit f_hit(input logic [4:0] d, input logic [31:0] i);
    return (d != 0) && (d == i[25:21] || (f_uses_rt(i) && d == i[20:16]));
  endfunction

  function automatic logic [31:0] f_oper(input logic [4:0] a, input logic [31:0] rdata);
    if (a == 0) return 32'd0;
    if (BYP && WbRegWrite && WbWriteRegister == a) return WbWriteData;
    return rdata;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cap = 0; p_on = 0; p_due = 0; p_dest = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit ordy, input bit wen,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] r1, input logic [31:0] r2);
    InValid = v; InInstr = ins; InPC = $urandom; OutReady = ordy;
    WbRegWrite = wen; WbWriteRegister = wa; WbWriteData = wd;
    ReadData1 = r1; ReadData2 = r2;
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic run_cycle();
    logic [31:0] i;
    bit stall, rdy, hs;
    #1;
    i = InInstr;
    stall = (m_valid && m_ld && f_hit(m_dest, i))
         || (p_on && (BYP ? (t < p_due) : (t <= p_due)) && f_hit(p_dest, i))
         || (!BYP && WbRegWrite && f_hit(WbWriteRegister, i));
    rdy = !stall && (!m_valid || OutReady);
    last_dut_rdy = InReady;
    chk("in_ready", 32'(InReady), 32'(rdy));
    chk("read_reg1", 32'(ReadRegister1), 32'(i[25:21]));
    chk("read_reg2", 32'(ReadRegister2), 32'(i[20:16]));
    m_cap = InValid && rdy;
    hs = m_valid && OutReady;
    if (hs && m_ld && m_dest != 0) begin
      p_on = 1; p_dest = m_dest; p_due = t + 1 + int'(LAT);
    end
    if (m_cap) begin
      m_valid = 1;
      m_rs = f_oper(i[25:21], ReadData1);
      m_rt = f_oper(i[20:16], ReadData2);
      m_imm = {{16{i[15]}}, i[15:0]};
      m_dest = f_dest(i);
      m_rw = (f_dest(i) != 0);
      m_ld = (i[31:26] == 6'h23);
      m_op = i[31:26];
      m_fn = i[5:0];
      m_pc = InPC;
    end else if (hs) begin
      m_valid = 0;
    end
    @(posedge Clk);
    t++;
    #1;
    chk("out_valid", 32'(OutValid), 32'(m_valid));
    if (m_valid) begin
      chk("out_rs", OutRsVal, m_rs);
      chk("out_rt", OutRtVal, m_rt);
      chk("out_imm", OutImm, m_imm);
      chk("out_dest", 32'(OutDest), 32'(m_dest));
      chk("out_rw", 32'(OutRegWrite), 32'(m_rw));
      chk("out_ld", 32'(OutIsLoad), 32'(m_ld));
      chk("out_op", 32'(OutOpcode), 32'(m_op));
      chk("out_fn", 32'(OutFunct), 32'(m_fn));
      chk("out_pc", OutPC, m_pc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(OutValid), 32'd0);
    chk({tag, "_rs"}, OutRsVal, 32'd0);
    chk({tag, "_dest"}, 32'(OutDest), 32'd0);
    chk({tag, "_pc"}, OutPC, 32'd0);
    chk({tag, "_op"}, 32'(OutOpcode), 32'd0);
  endtask

  localparam logic [31:0] LW5   = {6'h23, 5'd1, 5'd5, 16'd0};
  localparam logic [31:0] LW0   = {6'h23, 5'd1, 5'd0, 16'd4};
  localparam logic [31:0] ADD655 = {6'd0, 5'd5, 5'd5, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] ADD980 = {6'd0, 5'd8, 5'd0, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD200 = {6'd0, 5'd0, 5'd0, 5'd2, 5'd0, 6'h20};
  localparam logic [31:0] ADD712 = {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
  localparam logic [31:0] ADDI7  = {6'h08, 5'd0, 5'd7, 16'hFFF5};
  localparam logic [31:0] ORI3   = {6'h0D, 5'd2, 5'd3, 16'h00A5};

  initial begin
    int stalls;
    logic [31:0] pc_hold;
    logic [5:0] ops [12];
    ops = '{6'h00, 6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h03, 6'h02};

    drive(0, '0, 0, 0, '0, '0, '0, '0);
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    model_reset();
    @(posedge Clk); @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Same-cycle writeback of $8 feeding add $9,$8,$0
    drive(1, ADD980, 1, 1, 5'd8, 32'hDEADBEEF, 32'd0, 32'h5555AAAA);
    run_cycle();
    for (int k = 0; k < 3; k++) begin
      if (m_cap) break;
      drive(1, ADD980, 1, 0, 5'd0, 32'd0, 32'h11111111, 32'h5555AAAA);
      run_cycle();
    end
    chk("byp_dest", 32'(OutDest), 32'd9);
    chk("byp_rt_zero", OutRtVal, 32'd0);
    chk("byp_rs", OutRsVal, BYP ? 32'hDEADBEEF : 32'h11111111);

    // Load-use: lw $5 then add $6,$5,$5; bench drives Wb at the model's due cycle
    drive(1, LW5, 1, 0, '0, '0, $urandom, $urandom);
    run_cycle();
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1, ADD655, 1, p_on && (t == p_due), p_dest, 32'h1234,
            (t > p_due) ? 32'h1234 : 32'hBAD0, (t > p_due) ? 32'h1234 : 32'hBAD0);
      run_cycle();
      if (!last_dut_rdy) stalls++;
      if (m_cap) break;
    end
    chk("lu_stalls", stalls, 1 + LAT + (BYP ? 0 : 1));
    chk("lu_rs", OutRsVal, 32'h1234);
    chk("lu_rt", OutRtVal, 32'h1234);

    // $0 immunity
    drive(1, LW0, 1, 0, '0, '0, $urandom, $urandom);
    run_cycle();
    drive(1, ADD200, 1, 0, '0, '0, 32'hAAAA0001, 32'hAAAA0002);
    run_cycle();
    chk("z_ready", 32'(last_dut_rdy), 32'd1);
    chk("z_rs", OutRsVal, 32'd0);

    // Back-pressure for 3 cycles, then drain + capture in one cycle
    drive(0, ADDI7, 1, 0, '0, '0, '0, '0);
    run_cycle();
    drive(1, ADDI7, 1, 0, '0, '0, $urandom, $urandom);
    pc_hold = InPC;
    run_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1, ORI3, 0, 0, '0, '0, $urandom, $urandom);
      run_cycle();
      chk("bp_pc_hold", OutPC, pc_hold);
    end
    drive(1, ORI3, 1, 0, '0, '0, 32'h77, 32'h88);
    pc_hold = InPC;
    run_cycle();
    chk("bp_new_pc", OutPC, pc_hold);

    // Reset mid-stream with a load pending in the tracker and add held in ID/EX
    drive(1, LW5, 1, 0, '0, '0, $urandom, $urandom);
    run_cycle();
    drive(1, ADD712, 1, 0, '0, '0, $urandom, $urandom);
    run_cycle();
    drive(0, '0, 0, 0, '0, '0, '0, '0);
    Rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    model_reset();
    @(posedge Clk);
    t++;
    #1 Rst_n = 1'b1;
    drive(1, ADD655, 1, 0, '0, '0, $urandom, $urandom);
    run_cycle();
    chk("rst_trk_empty", 32'(last_dut_rdy), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 11'($urandom)};
      drive($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
